stage_mem: RTL and testbench
============================

Name: stage_mem

Overview:
Memory-access stage of the 5-stage RV32I pipeline, directly downstream of the execute stage via the EX/MEM latch. Non-memory instructions pass through combinationally. Loads and stores are performed over a byte-wide req/ack memory port, one byte per transfer, using a small FSM. The stage raises stallreq to freeze the upstream pipeline until the access completes, then hands the write-back triple to MEM/WB.

Parameters:
ADDR_WIDTH, 32, byte address width on the memory port
XLEN, 32, register/data width; fixed at 32 for RV32I

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge)
mem_op  input  4  `MemOpBus: MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
mem_addr  input  ADDR_WIDTH  effective address, computed by EX
mem_wdata  input  XLEN  store data (rs2 value)
reg_waddr_i  input  5  destination register from EX/MEM
we_i  input  1  register write enable from EX/MEM
reg_wdata_i  input  XLEN  ALU result from EX/MEM
reg_waddr_o  output  5  to MEM/WB
we_o  output  1  to MEM/WB
reg_wdata_o  output  XLEN  ALU result, or extended load data
stallreq  output  1  1 = hold IF..MEM latches this cycle
bus_req  output  1  byte transfer request
bus_we  output  1  1 = write byte, 0 = read byte
bus_addr  output  ADDR_WIDTH  byte address
bus_dout  output  8  write byte
bus_din  input  8  read byte; valid when bus_ack = 1
bus_ack  input  1  transfer done; sampled on clk edge while bus_req = 1

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Registered signals: cnt[1:0] (byte index), buf[31:0] (assembled load bytes), bus_* outputs.
- Byte count n: 1 for B/BU, 2 for H/HU, 4 for W. Byte k uses address mem_addr+k, little-endian, with wrap at 2^ADDR_WIDTH. No alignment check; misaligned accesses are legal.
- IDLE, mem_op = MEM_NOP: pass-through (reg_*_o = reg_*_i), stallreq = 0, zero latency.
- IDLE, mem_op != NOP: stallreq = 1 combinationally. On the next edge: go to ACCESS with cnt = 0, bus_req = 1, bus_addr = mem_addr, bus_we = store, bus_dout = mem_wdata[7:0].
- ACCESS: stallreq = 1. On an edge with bus_ack = 1:
  - Loads capture buf[8*cnt+:8] = bus_din.
  - If cnt = n-1: go to DONE and drop bus_req.
  - Otherwise: cnt += 1, bus_addr += 1, bus_dout = next byte, and bus_req stays 1 (no idle gap).
  - If bus_ack = 0: hold all bus outputs (wait states are unbounded).
- DONE: stallreq = 0 for exactly one cycle; outputs are valid; next state is IDLE. EX/MEM inputs are held stable from IDLE through DONE because the latch is stalled.
- Load result:
  - LB/LH: sign-extend buf[7:0] / buf[15:0].
  - LBU/LHU: zero-extend.
  - LW: buf.
  - Driven on reg_wdata_o in DONE; we_o = we_i.
- Store result: reg_wdata_o = reg_wdata_i and we_o = we_i (decoder guarantees 0).
- Bus outputs in IDLE/DONE: bus_req = 0, bus_we = 0, bus_addr and bus_dout hold their last values.
- Throughput: a new memory op presented in the IDLE cycle after DONE starts immediately. Back-to-back accesses are allowed.
- Reset (rst = 0): while asserted, all outputs are forced to 0. At the edge, state = IDLE, cnt = 0, buf = 0, bus_req = 0, bus_we = 0, bus_addr = 0, bus_dout = 0.
- Reset mid-ACCESS: aborts the transfer. bus_req is 0 from the next cycle, and any in-flight ack is ignored.
- Unknown mem_op encoding: treated as MEM_NOP.

Decomposition:
- defines.v gets:
  - `MemOpBus and the MEM_* constants.
  - Mem state encodings MEM_ST_IDLE/ACCESS/DONE.
- One combinational sub-module, mem_load_ext (op + buf -> extended XLEN result). It is reused by any future cache path.

Test Plan:
- Non-memory op: mem_op = NOP, reg_wdata_i = 0xDEADBEEF, we_i = 1, waddr = 5 -> same values on outputs in the same cycle, stallreq = 0, bus_req never 1.
- LW, zero wait: addr 0x100, memory 0x100..0x103 = 78 56 34 12, ack in every req cycle -> four bus_req cycles at addresses 0x100..0x103, stallreq high for 5 cycles, DONE reg_wdata_o = 0x12345678.
- LB / LBU with waits: byte 0x80 at 0x203, ack after 3 wait cycles -> LB gives 0xFFFFFF80, LBU gives 0x00000080. bus_addr and bus_req hold steady during the waits.
- SH, misaligned: addr 0x1FF, mem_wdata = 0xAAAA_BEEF -> writes EF to 0x1FF, then BE to 0x200, bus_we = 1. Memory elsewhere is unchanged, we_o = 0.
- Reset mid-access: LW, rst = 0 after the 2nd ack -> next cycle bus_req = 0, stallreq = 0, outputs 0, state IDLE. After rst = 1, a fresh LHU at 0x10 (bytes 34 F2) returns 0x0000F234.
- Back-to-back: SW 0x11223344 @0x40, then LW @0x40 -> load returns 0x11223344. The new access starts in the IDLE cycle right after DONE.

Source files
------------

// File: rtl/stage_mem_pkg.sv
// Shared types for the memory-access stage: memory op encodings, FSM states, op decode helpers.
package stage_mem_pkg;

  typedef enum logic [3:0] {
    MemNop = 4'd0,
    MemLb  = 4'd1,
    MemLh  = 4'd2,
    MemLw  = 4'd3,
    MemLbu = 4'd4,
    MemLhu = 4'd5,
    MemSb  = 4'd6,
    MemSh  = 4'd7,
    MemSw  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } mem_st_e;

  // Byte count of an access; 0 marks NOP and any unknown encoding.
  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    logic [2:0] n;
    case (op)
      MemLb, MemLbu, MemSb: n = 3'd1;
      MemLh, MemLhu, MemSh: n = 3'd2;
      MemLw, MemSw:         n = 3'd4;
      default:              n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MemSb) || (op == MemSh) || (op == MemSw);
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of assembled load bytes into a register-width result.
module mem_load_ext
  import stage_mem_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] buf_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = buf_i;
    case (op_i)
      MemLb:   data_o = {{24{buf_i[7]}}, buf_i[7:0]};
      MemLh:   data_o = {{16{buf_i[15]}}, buf_i[15:0]};
      MemLbu:  data_o = {24'h0, buf_i[7:0]};
      MemLhu:  data_o = {16'h0, buf_i[15:0]};
      default: data_o = buf_i;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Pipeline memory stage: pass-through for non-memory ops, byte-serial req/ack access for
// loads and stores with a stall request held until the access completes.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            mem_op,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [XLEN-1:0]       mem_wdata,
  input  logic [4:0]            reg_waddr_i,
  input  logic                  we_i,
  input  logic [XLEN-1:0]       reg_wdata_i,
  output logic [4:0]            reg_waddr_o,
  output logic                  we_o,
  output logic [XLEN-1:0]       reg_wdata_o,
  output logic                  stallreq,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_dout,
  input  logic [7:0]            bus_din,
  input  logic                  bus_ack
);

  mem_st_e               state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [XLEN-1:0]       buf_q, buf_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]            bus_dout_q, bus_dout_d;

  logic [2:0]      n_bytes;
  logic            is_mem, is_store, is_load, last_byte;
  logic [1:0]      cnt_nxt;
  logic [XLEN-1:0] load_data;

  assign n_bytes   = op_bytes(mem_op);
  assign is_mem    = (n_bytes != 3'd0);
  assign is_store  = op_is_store(mem_op);
  assign is_load   = is_mem && !is_store;
  assign last_byte = (({1'b0, cnt_q} + 3'd1) == n_bytes);
  assign cnt_nxt   = cnt_q + 2'd1;

  mem_load_ext u_load_ext (
    .op_i   (mem_op),
    .buf_i  (buf_q),
    .data_o (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    bus_req_d  = bus_req_q;
    bus_we_d   = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_dout_d = bus_dout_q;
    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          state_d    = StAccess;
          cnt_d      = 2'd0;
          bus_req_d  = 1'b1;
          bus_we_d   = is_store;
          bus_addr_d = mem_addr;
          bus_dout_d = mem_wdata[7:0];
        end
      end
      StAccess: begin
        if (bus_ack) begin
          if (!is_store) buf_d[{cnt_q, 3'b000} +: 8] = bus_din;
          if (last_byte) begin
            state_d   = StDone;
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
          end else begin
            // Next byte issues on the following cycle with no idle gap on the bus.
            cnt_d      = cnt_nxt;
            bus_addr_d = bus_addr_q + ADDR_WIDTH'(1);
            bus_dout_d = mem_wdata[{cnt_nxt, 3'b000} +: 8];
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      buf_q      <= '0;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_dout_q <= 8'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      bus_req_q  <= bus_req_d;
      bus_we_q   <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_dout_q <= bus_dout_d;
    end
  end

  // Every output is forced low while reset is held, independent of the registered state.
  always_comb begin
    reg_waddr_o = 5'd0;
    we_o        = 1'b0;
    reg_wdata_o = '0;
    stallreq    = 1'b0;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_dout    = 8'h0;
    if (rst) begin
      reg_waddr_o = reg_waddr_i;
      we_o        = we_i;
      reg_wdata_o = ((state_q == StDone) && is_load) ? load_data : reg_wdata_i;
      stallreq    = ((state_q == StIdle) && is_mem) || (state_q == StAccess);
      bus_req     = bus_req_q;
      bus_we      = bus_we_q;
      bus_addr    = bus_addr_q;
      bus_dout    = bus_dout_q;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: driver pushes expected write-back and bus transfers,
// a bus slave and a write-back monitor pop and compare independently.
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata, reg_wdata_i, reg_wdata_o, bus_addr;
  logic [4:0]  reg_waddr_i, reg_waddr_o;
  logic        we_i, we_o, stallreq, bus_req, bus_we, bus_ack;
  logic [7:0]  bus_dout, bus_din;

  always #5 clk = ~clk;

  stage_mem #(.ADDR_WIDTH(32), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_op     (mem_op),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .reg_waddr_i(reg_waddr_i),
    .we_i       (we_i),
    .reg_wdata_i(reg_wdata_i),
    .reg_waddr_o(reg_waddr_o),
    .we_o       (we_o),
    .reg_wdata_o(reg_wdata_o),
    .stallreq   (stallreq),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_dout   (bus_dout),
    .bus_din    (bus_din),
    .bus_ack    (bus_ack)
  );

  typedef struct packed {logic [4:0] waddr; logic we; logic [31:0] wdata;} wb_t;
  typedef struct packed {logic [31:0] addr; logic we; logic [7:0] dout;} xfer_t;

  wb_t        exp_q[$];
  xfer_t      bus_q[$];
  bit [7:0]   ref_mem[bit [31:0]];
  bit [7:0]   slv_mem[bit [31:0]];
  int         checks = 0, passes = 0;
  bit         presenting = 0, done_seen = 0;
  int         stall_cnt = 0, wait_sum = 0, ack_cnt = 0, force_wait = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rd_slv(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 8'h00;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    slv_mem[a] = d;
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  // Write-back monitor: DUT result is valid whenever a presented op has stallreq low.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst && presenting && !done_seen) begin
        if (stallreq) stall_cnt++;
        else begin
          if (exp_q.size() == 0) check("wb_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_q.pop_front();
            check("wb", 64'({reg_waddr_o, we_o, reg_wdata_o}), 64'(e));
          end
          done_seen = 1;
        end
      end
    end
  end

  // Byte-bus slave with random wait states; each new request is matched to the expected list.
  initial begin
    xfer_t cur, x;
    bit    active = 0;
    int    waits = 0;
    bus_ack = 1'b0;
    bus_din = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus_ack = 1'b0;
        active  = 0;
        continue;
      end
      if (bus_ack) begin
        if (cur.we) slv_mem[cur.addr] = cur.dout;
        active  = 0;
        bus_ack = 1'b0;
        ack_cnt++;
      end
      if (bus_req && !active) begin
        active = 1;
        cur    = '{bus_addr, bus_we, bus_dout};
        if (bus_q.size() == 0) check("xfer_unexpected", 64'(cur), 64'(0));
        else begin
          x = bus_q.pop_front();
          check("xfer", 64'(cur), 64'(x));
        end
        waits = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
      end else if (active) begin
        check("xfer_hold", 64'({bus_req, bus_addr, bus_we, bus_dout}), 64'({1'b1, cur}));
      end
      if (active) begin
        if (waits == 0) begin
          bus_ack = 1'b1;
          bus_din = cur.we ? 8'($urandom) : rd_slv(cur.addr);
        end else begin
          waits--;
          wait_sum++;
          bus_din = 8'($urandom);
        end
      end
    end
  end

  // Reference model: builds expected bus transfers and write-back result from the op rules.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] waddr, input logic we, input logic [31:0] alu);
    int          n;
    bit          store, sgn;
    logic [31:0] v, a;
    logic [7:0]  b;
    wb_t         e;
    n = 0; store = 0; sgn = 0;
    case (op)
      MemLb:  begin n = 1; sgn = 1; end
      MemLbu: n = 1;
      MemLh:  begin n = 2; sgn = 1; end
      MemLhu: n = 2;
      MemLw:  n = 4;
      MemSb:  begin n = 1; store = 1; end
      MemSh:  begin n = 2; store = 1; end
      MemSw:  begin n = 4; store = 1; end
      default: n = 0;
    endcase
    v = 32'h0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      b = 8'(wdata >> (8 * k));
      bus_q.push_back('{a, store, b});
      if (store) ref_mem[a] = b;
      else v = v + (32'(rd_ref(a)) << (8 * k));
    end
    if (n != 0 && !store && sgn && v[8*n-1]) v = v - (32'h1 << (8 * n));
    e = '{waddr, we, (n != 0 && !store) ? v : alu};
    exp_q.push_back(e);
    mem_op = op; mem_addr = addr; mem_wdata = wdata;
    reg_waddr_i = waddr; we_i = we; reg_wdata_i = alu;
    stall_cnt = 0; wait_sum = 0; done_seen = 0; presenting = 1;
    for (int i = 0; i < 300 && !done_seen; i++) @(posedge clk);
    #1;
    if (!done_seen) begin
      checks++;
      $display("FAIL timeout: op %0d got no result within 300 cycles", op);
      finish_run();
    end
    check("stall_cycles", 64'(stall_cnt), 64'((n != 0) ? n + 1 + wait_sum : 0));
    presenting = 0;
    mem_op = MemNop;
  endtask

  initial begin
    int base;
    logic [3:0]  rop;
    logic [31:0] raddr;
    rst = 1'b0;
    mem_op = MemLw; mem_addr = 32'h1234; mem_wdata = 32'hFFFF_FFFF;
    reg_waddr_i = 5'd31; we_i = 1'b1; reg_wdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    check("reset_outputs", 64'({reg_waddr_o, we_o, reg_wdata_o, stallreq}), 64'(0));
    check("reset_bus", 64'({bus_req, bus_we, bus_addr, bus_dout}), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    mem_op = MemNop; rst = 1'b1;
    @(negedge clk);
    check("post_reset_bus", 64'({bus_req, bus_we, bus_addr, bus_dout, stallreq}), 64'(0));
    @(posedge clk); #1;

    // Pass-through, then zero-wait LW.
    run_op(MemNop, 32'h0, 32'h0, 5'd5, 1'b1, 32'hDEAD_BEEF);
    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    force_wait = 0;
    run_op(MemLw, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0);

    // Signed and unsigned byte loads with three wait cycles.
    preload(32'h203, 8'h80);
    force_wait = 3;
    run_op(MemLb, 32'h203, 32'h0, 5'd8, 1'b1, 32'h0);
    run_op(MemLbu, 32'h203, 32'h0, 5'd9, 1'b1, 32'h0);

    // Misaligned halfword store across 0x1FF/0x200.
    preload(32'h1FE, 8'h11); preload(32'h1FF, 8'h22);
    preload(32'h200, 8'h33); preload(32'h201, 8'h44);
    force_wait = -1;
    run_op(MemSh, 32'h1FF, 32'hAAAA_BEEF, 5'd0, 1'b0, 32'h55);
    check("sh_bytes", 64'({rd_slv(32'h1FE), rd_slv(32'h1FF), rd_slv(32'h200), rd_slv(32'h201)}),
          64'(32'h11EF_BE44));

    // Reset during an LW after the second byte has been acknowledged.
    preload(32'h300, 8'hA1); preload(32'h301, 8'hB2);
    preload(32'h302, 8'hC3); preload(32'h303, 8'hD4);
    force_wait = 2;
    base = ack_cnt;
    for (int k = 0; k < 4; k++) bus_q.push_back('{32'h300 + 32'(k), 1'b0, 8'h00});
    mem_op = MemLw; mem_addr = 32'h300; mem_wdata = 32'h0;
    reg_waddr_i = 5'd3; we_i = 1'b1; reg_wdata_i = 32'h9999_9999;
    for (int i = 0; i < 300 && ack_cnt < base + 2; i++) @(posedge clk);
    #1;
    check("reset_abort_acks", 64'(ack_cnt - base), 64'(2));
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_reset", 64'({bus_req, stallreq, reg_waddr_o, we_o, reg_wdata_o}), 64'(0));
    @(posedge clk); #1;
    bus_q.delete();
    mem_op = MemNop; rst = 1'b1;
    @(negedge clk);
    check("abort_idle", 64'({bus_req, stallreq, reg_wdata_o}), 64'({2'b00, 32'h9999_9999}));
    @(posedge clk); #1;
    preload(32'h10, 8'h34); preload(32'h11, 8'hF2);
    force_wait = -1;
    run_op(MemLhu, 32'h10, 32'h0, 5'd10, 1'b1, 32'h0);

    // Back-to-back store then load of the same word, plus an address-wrapping load.
    run_op(MemSw, 32'h40, 32'h1122_3344, 5'd0, 1'b0, 32'h0);
    run_op(MemLw, 32'h40, 32'h0, 5'd11, 1'b1, 32'h0);
    preload(32'hFFFF_FFFF, 8'h9A); preload(32'h0, 8'h0B);
    run_op(MemLh, 32'hFFFF_FFFF, 32'h0, 5'd12, 1'b1, 32'h0);

    // Random mix including unknown encodings and wrap-around windows.
    for (int i = 0; i < 80; i++) begin
      rop = ($urandom_range(0, 9) == 9) ? 4'hF : 4'($urandom_range(0, 8));
      raddr = $urandom_range(0, 1) ? 32'h1000 + $urandom_range(0, 15)
                                   : 32'hFFFF_FFFC + $urandom_range(0, 3);
      run_op(rop, raddr, $urandom, 5'($urandom), 1'($urandom), $urandom);
    end

    check("bus_queue_empty", 64'(bus_q.size()), 64'(0));
    check("wb_queue_empty", 64'(exp_q.size()), 64'(0));
    finish_run();
  end

endmodule
